// File: rtl/apb_pkg.sv
// Shared APB initiator types: FSM state encoding and bus widths.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles; o_last flags the final permitted cycle before abort.
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_last
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_count && !o_last) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_last = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_initiator.sv
// Single-outstanding request/response to APB initiator.
// Optional ACCESS timeout is compiled in with `define APB_INIT_TIMEOUT_EN.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [APB_ADDR_W-1:0] req_addr,
    input  logic                  req_write,
    input  logic [APB_DATA_W-1:0] req_wdata,
    input  logic [APB_STRB_W-1:0] req_wstrb,
    input  logic [2:0]            req_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [APB_ADDR_W-1:0] out_paddr,
    output logic                  out_psel,
    output logic                  out_penable,
    output logic [2:0]            out_pprot,
    output logic                  out_pwrite,
    output logic [APB_DATA_W-1:0] out_pwdata,
    output logic [APB_STRB_W-1:0] out_pstrb,
    input  logic                  out_pready,
    input  logic [APB_DATA_W-1:0] out_prdata,
    input  logic                  out_pslverr
);

    apb_state_e r_state;
    apb_state_e w_nextState;

    logic [APB_ADDR_W-1:0] r_addr;
    logic                  r_write;
    logic [APB_DATA_W-1:0] r_wdata;
    logic [APB_STRB_W-1:0] r_wstrb;
    logic [2:0]            r_prot;
    logic [APB_DATA_W-1:0] r_rdata;
    logic                  r_err;
    logic                  w_timeout;

`ifdef APB_INIT_TIMEOUT_EN
    apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .i_clear (r_state == ST_SETUP),
        .i_count (r_state == ST_ACCESS),
        .o_last  (w_timeout)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A timeout only applies when the slave did not answer in that same cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_nextState = ST_SETUP;
            ST_SETUP:  w_nextState = ST_ACCESS;
            ST_ACCESS: if (out_pready || w_timeout) w_nextState = ST_RESP;
            ST_RESP:   if (rsp_ready) w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (r_state == ST_IDLE) && !reset;
        out_psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
        out_penable = (r_state == ST_ACCESS);
        rsp_valid   = (r_state == ST_RESP);
    end

    // Write-only fields are zeroed at capture so reads drive 0 on the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_prot  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_wdata <= req_write ? req_wdata : '0;
                r_wstrb <= req_write ? req_wstrb : '0;
                r_prot  <= req_prot;
            end
            if (r_state == ST_ACCESS) begin
                if (out_pready) begin
                    r_rdata <= r_write ? '0 : out_prdata;
                    r_err   <= out_pslverr;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign out_paddr  = r_addr;
    assign out_pwrite = r_write;
    assign out_pwdata = r_wdata;
    assign out_pstrb  = r_wstrb;
    assign out_pprot  = r_prot;
    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed self-checking bench for apb_initiator (timeout case under APB_INIT_TIMEOUT_EN).
module tb_apb_initiator;

    logic        clock;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqWrite;
    logic [31:0] reqWdata;
    logic [3:0]  reqWstrb;
    logic [2:0]  reqProt;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic [31:0] pAddr;
    logic        pSel;
    logic        pEnable;
    logic [2:0]  pProt;
    logic        pWrite;
    logic [31:0] pWdata;
    logic [3:0]  pStrb;
    logic        pReady;
    logic [31:0] pRdata;
    logic        pSlverr;

    int checks = 0;
    int errors = 0;

    apb_initiator #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (reqValid),
        .req_ready   (reqReady),
        .req_addr    (reqAddr),
        .req_write   (reqWrite),
        .req_wdata   (reqWdata),
        .req_wstrb   (reqWstrb),
        .req_prot    (reqProt),
        .rsp_valid   (rspValid),
        .rsp_ready   (rspReady),
        .rsp_rdata   (rspRdata),
        .rsp_err     (rspErr),
        .out_paddr   (pAddr),
        .out_psel    (pSel),
        .out_penable (pEnable),
        .out_pprot   (pProt),
        .out_pwrite  (pWrite),
        .out_pwdata  (pWdata),
        .out_pstrb   (pStrb),
        .out_pready  (pReady),
        .out_prdata  (pRdata),
        .out_pslverr (pSlverr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic w,
                                 input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        reqValid = v;
        reqAddr  = a;
        reqWrite = w;
        reqWdata = d;
        reqWstrb = s;
        reqProt  = p;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rspReady = 1'b0;
        pReady   = 1'b0;
        pRdata   = 32'h0;
        pSlverr  = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 3'h0);

        stepCycle();
        stepCycle();
        checkBit("rst_psel", pSel, 1'b0);
        checkBit("rst_penable", pEnable, 1'b0);
        checkBit("rst_rsp_valid", rspValid, 1'b0);
        checkOutput("rst_paddr", pAddr, 32'h0);
        checkOutput("rst_rdata", rspRdata, 32'h0);
        checkBit("rst_err", rspErr, 1'b0);
        reset = 1'b0;
        #1;
        checkBit("rst_req_ready", reqReady, 1'b1);

        // Zero-wait write; pready held high early must not shorten SETUP.
        $display("[TB] write, zero wait states");
        applyStimulus(1'b1, 32'h1000_2000, 1'b1, 32'h0000_A5A5, 4'h3, 3'b010);
        pReady   = 1'b1;
        pRdata   = 32'hDEAD_BEEF;
        rspReady = 1'b1;
        stepCycle();
        reqValid = 1'b0;
        checkBit("wr_setup_psel", pSel, 1'b1);
        checkBit("wr_setup_penable", pEnable, 1'b0);
        checkBit("wr_setup_req_ready", reqReady, 1'b0);
        checkOutput("wr_setup_paddr", pAddr, 32'h1000_2000);
        checkOutput("wr_setup_pwdata", pWdata, 32'h0000_A5A5);
        checkOutput("wr_setup_pstrb", {28'h0, pStrb}, 32'h3);
        checkOutput("wr_setup_pprot", {29'h0, pProt}, 32'h2);
        checkBit("wr_setup_pwrite", pWrite, 1'b1);
        stepCycle();
        checkBit("wr_access_psel", pSel, 1'b1);
        checkBit("wr_access_penable", pEnable, 1'b1);
        checkOutput("wr_access_pstrb", {28'h0, pStrb}, 32'h3);
        stepCycle();
        checkBit("wr_resp_valid", rspValid, 1'b1);
        checkBit("wr_resp_psel", pSel, 1'b0);
        checkBit("wr_resp_penable", pEnable, 1'b0);
        checkOutput("wr_resp_rdata", rspRdata, 32'h0);
        checkBit("wr_resp_err", rspErr, 1'b0);
        pReady = 1'b0;
        stepCycle();
        checkBit("wr_idle_req_ready", reqReady, 1'b1);
        checkBit("wr_idle_rsp_valid", rspValid, 1'b0);

        // Read with three wait states; write-only fields must be masked.
        $display("[TB] read, three wait states");
        applyStimulus(1'b1, 32'h1000_2004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b001);
        stepCycle();
        reqValid = 1'b0;
        checkOutput("rd_setup_pstrb", {28'h0, pStrb}, 32'h0);
        checkOutput("rd_setup_pwdata", pWdata, 32'h0);
        checkBit("rd_setup_pwrite", pWrite, 1'b0);
        stepCycle();
        checkBit("rd_access1_penable", pEnable, 1'b1);
        stepCycle();
        checkBit("rd_access2_penable", pEnable, 1'b1);
        stepCycle();
        checkBit("rd_access3_penable", pEnable, 1'b1);
        checkOutput("rd_access3_paddr", pAddr, 32'h1000_2004);
        stepCycle();
        checkBit("rd_access4_penable", pEnable, 1'b1);
        checkBit("rd_access4_rsp_valid", rspValid, 1'b0);
        pReady = 1'b1;
        pRdata = 32'h0000_1234;
        stepCycle();
        pReady = 1'b0;
        pRdata = 32'h0;
        checkBit("rd_resp_valid", rspValid, 1'b1);
        checkBit("rd_resp_psel", pSel, 1'b0);
        checkOutput("rd_resp_rdata", rspRdata, 32'h0000_1234);
        checkBit("rd_resp_err", rspErr, 1'b0);
        stepCycle();
        checkBit("rd_idle_req_ready", reqReady, 1'b1);

        // Slave error with a stalled response channel; bus noise must be ignored.
        $display("[TB] read error, response backpressure");
        rspReady = 1'b0;
        applyStimulus(1'b1, 32'h1000_3000, 1'b0, 32'h0, 4'h0, 3'b000);
        stepCycle();
        reqValid = 1'b0;
        stepCycle();
        pReady  = 1'b1;
        pSlverr = 1'b1;
        pRdata  = 32'h55AA_55AA;
        stepCycle();
        pRdata  = 32'h1111_1111;
        pSlverr = 1'b0;
        applyStimulus(1'b1, 32'h2000_0000, 1'b1, 32'h0, 4'hF, 3'b000);
        for (int i = 0; i < 5; i++) begin
            checkBit("err_hold_valid", rspValid, 1'b1);
            checkBit("err_hold_err", rspErr, 1'b1);
            checkOutput("err_hold_rdata", rspRdata, 32'h55AA_55AA);
            checkBit("err_hold_req_ready", reqReady, 1'b0);
            checkBit("err_hold_psel", pSel, 1'b0);
            checkOutput("err_hold_paddr", pAddr, 32'h1000_3000);
            stepCycle();
        end
        pReady   = 1'b0;
        reqValid = 1'b0;
        rspReady = 1'b1;
        stepCycle();
        checkBit("err_idle_rsp_valid", rspValid, 1'b0);
        checkBit("err_idle_req_ready", reqReady, 1'b1);

        // Reset while in ACCESS abandons the transfer.
        $display("[TB] reset during access");
        applyStimulus(1'b1, 32'h1000_4000, 1'b1, 32'h0000_00FF, 4'h1, 3'b000);
        stepCycle();
        reqValid = 1'b0;
        stepCycle();
        checkBit("rstacc_in_access", pEnable, 1'b1);
        reset = 1'b1;
        stepCycle();
        checkBit("rstacc_psel", pSel, 1'b0);
        checkBit("rstacc_penable", pEnable, 1'b0);
        checkBit("rstacc_rsp_valid", rspValid, 1'b0);
        checkOutput("rstacc_paddr", pAddr, 32'h0);
        reset  = 1'b0;
        pReady = 1'b1;
        #1;
        checkBit("rstacc_req_ready", reqReady, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkBit("rstacc_no_rsp", rspValid, 1'b0);
            checkBit("rstacc_no_psel", pSel, 1'b0);
        end
        pReady = 1'b0;

`ifdef APB_INIT_TIMEOUT_EN
        // Slave never answers: abort after eight ACCESS cycles.
        $display("[TB] timeout");
        pRdata = 32'hCAFE_F00D;
        applyStimulus(1'b1, 32'h1000_5000, 1'b0, 32'h0, 4'h0, 3'b000);
        stepCycle();
        reqValid = 1'b0;
        stepCycle();
        for (int i = 0; i < 8; i++) begin
            checkBit("to_access_penable", pEnable, 1'b1);
            checkBit("to_access_rsp_valid", rspValid, 1'b0);
            stepCycle();
        end
        checkBit("to_resp_psel", pSel, 1'b0);
        checkBit("to_resp_penable", pEnable, 1'b0);
        checkBit("to_resp_valid", rspValid, 1'b1);
        checkBit("to_resp_err", rspErr, 1'b1);
        checkOutput("to_resp_rdata", rspRdata, 32'h0);
        stepCycle();
        checkBit("to_idle_req_ready", reqReady, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
